// File: rtl/mdio_controller.sv
// rtl/mdio_controller.sv - Clause-22 MDIO management master, MDC = clk/2, 32-bit frames
module mdio_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic [15:0] MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic [31:0] frame_q, frame_d;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic        phase_q, phase_d;
  logic        is_read_q, is_read_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        mdc_q, mdc_d;
  logic        out_q, out_d;
  logic        oe_q, oe_d;
  logic        rdy_q, rdy_d;
  logic [4:0]  next_idx;
  logic        next_drive;
  logic [15:0] shadow_shift;

  // Only the serial lane of the PHY input bus carries data.
  logic unused_mdio_in;
  assign unused_mdio_in = ^MDIO_IN[15:1];

  assign next_idx     = bit_idx_q - 5'd1;
  assign next_drive   = !is_read_q || (next_idx >= 5'd18);
  assign shadow_shift = {shadow_q[14:0], MDIO_IN[0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      bit_idx_q <= '0;
      phase_q   <= 1'b0;
      is_read_q <= 1'b0;
      shadow_q  <= '0;
      rd_data_q <= '0;
      mdc_q     <= 1'b0;
      out_q     <= 1'b0;
      oe_q      <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_idx_q <= bit_idx_d;
      phase_q   <= phase_d;
      is_read_q <= is_read_d;
      shadow_q  <= shadow_d;
      rd_data_q <= rd_data_d;
      mdc_q     <= mdc_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      rdy_q     <= rdy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_idx_d = bit_idx_q;
    phase_d   = phase_q;
    is_read_d = is_read_q;
    shadow_d  = shadow_q;
    rd_data_d = rd_data_q;
    mdc_d     = mdc_q;
    out_d     = out_q;
    oe_d      = oe_q;
    rdy_d     = 1'b0;
    case (state_q)
      IDLE: begin
        mdc_d = 1'b0;
        out_d = 1'b0;
        oe_d  = 1'b0;
        if (MDIO_START) begin
          state_d   = ACTIVE;
          frame_d   = T_DATA;
          bit_idx_d = 5'd31;
          phase_d   = 1'b0;
          is_read_d = (T_DATA[29:28] == 2'b10);
          out_d     = T_DATA[31];
          oe_d      = 1'b1;
        end
      end
      ACTIVE: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          mdc_d   = 1'b1;
        end else begin
          // End of high phase: PHY data bit is stable here, then advance to next bit.
          phase_d = 1'b0;
          mdc_d   = 1'b0;
          if (is_read_q && (bit_idx_q <= 5'd15)) begin
            shadow_d = shadow_shift;
          end
          if (bit_idx_q == 5'd0) begin
            state_d = IDLE;
            out_d   = 1'b0;
            oe_d    = 1'b0;
            if (is_read_q) begin
              rd_data_d = shadow_shift;
              rdy_d     = 1'b1;
            end
          end else begin
            bit_idx_d = next_idx;
            oe_d      = next_drive;
            out_d     = next_drive ? frame_q[next_idx] : 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MDC      = mdc_q;
  assign MDIO_OUT = out_q;
  assign MDIO_OE  = oe_q;
  assign RD_DATA  = rd_data_q;
  assign DATA_RDY = rdy_q;

endmodule

// File: tb/tb_mdio_controller.sv
// tb/tb_mdio_controller.sv - scoreboard bench for mdio_controller
module tb_mdio_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] tdata = '0;
  logic [15:0] mdio_in = '0;
  logic        mdc, mdio_out, mdio_oe, data_rdy;
  logic [15:0] rd_data;

  mdio_controller dut (
    .clk(clk), .rst(rst), .MDIO_START(start), .T_DATA(tdata), .MDIO_IN(mdio_in),
    .MDC(mdc), .MDIO_OUT(mdio_out), .MDIO_OE(mdio_oe), .RD_DATA(rd_data), .DATA_RDY(data_rdy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          e0;
    logic [31:0] out_bits;
    logic [31:0] oe_bits;
    bit          is_read;
    logic [15:0] rd;
  } exp_t;
  exp_t expq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // PHY model: presents read data bit n after the MDC rise of bit n.
  logic [15:0] phy_data = '0;
  int          phy_rise = 0;
  always @(posedge mdc or negedge rst) begin
    if (!rst) begin
      phy_rise <= 0;
      mdio_in  <= '0;
    end else begin
      phy_rise <= (phy_rise == 31) ? 0 : phy_rise + 1;
      mdio_in  <= {15'($urandom), (phy_rise >= 16) ? phy_data[31 - phy_rise] : 1'b1};
    end
  end

  // Monitor: reassembles frames from MDC rises and scores DATA_RDY pulses.
  logic        mdc_prev = 1'b0;
  bit          in_frame = 1'b0;
  int          nrise = 0;
  int          rdy_cyc = -1;
  int          end_cyc = -1;
  logic [15:0] rdy_val = '0;
  logic [31:0] got_out = '0;
  logic [31:0] got_oe = '0;
  exp_t        cur;

  always @(negedge clk) begin
    if (!rst) begin
      in_frame = 1'b0;
      nrise    = 0;
      rdy_cyc  = -1;
      end_cyc  = -1;
      mdc_prev = 1'b0;
    end else begin
      if (mdc && !mdc_prev) begin
        if (!in_frame) begin
          if (expq.size() == 0) begin
            fail("unexpected_frame", cyc, -1);
          end else begin
            cur      = expq.pop_front();
            in_frame = 1'b1;
            nrise    = 0;
            check("frame_start_cycle", cyc, cur.e0 + 1);
          end
        end
        if (in_frame) begin
          got_out = {got_out[30:0], mdio_out};
          got_oe  = {got_oe[30:0], mdio_oe};
          nrise++;
          if (nrise == 32) begin
            check("frame_last_rise_cycle", cyc, cur.e0 + 63);
            check("mdio_out_bits", got_out, cur.out_bits);
            check("mdio_oe_bits", got_oe, cur.oe_bits);
            end_cyc = cur.e0 + 64;
            if (cur.is_read) begin
              rdy_cyc = cur.e0 + 64;
              rdy_val = cur.rd;
            end
            in_frame = 1'b0;
          end
        end
      end
      if (cyc == end_cyc) begin
        check("idle_after_frame", {29'd0, mdc, mdio_oe, mdio_out}, 32'd0);
        end_cyc = -1;
      end
      if (data_rdy) begin
        if (cyc == rdy_cyc) check("rd_data", rd_data, rdy_val);
        else fail("unexpected_data_rdy", cyc, rdy_cyc);
        rdy_cyc = -1;
      end else if (rdy_cyc >= 0 && cyc == rdy_cyc) begin
        fail("missing_data_rdy", cyc, rdy_cyc);
        rdy_cyc = -1;
      end
      mdc_prev = mdc;
    end
  end

  task automatic run_frame(input logic [31:0] td, input logic [31:0] eo, input logic [31:0] eoe,
                           input bit rd, input logic [15:0] rdv);
    exp_t e;
    @(negedge clk);
    tdata    = td;
    start    = 1'b1;
    phy_data = rdv;
    e.e0 = cyc + 1; e.out_bits = eo; e.oe_bits = eoe; e.is_read = rd; e.rd = rdv;
    expq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    tdata = $urandom();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int c;
    wait_cycles(3);
    check("reset_outputs", {13'd0, mdc, mdio_out, mdio_oe, data_rdy, rd_data}, 32'd0);
    rst = 1'b1;
    wait_cycles(2);

    run_frame(32'h508AABCD, 32'h508AABCD, 32'hFFFFFFFF, 1'b0, 16'h0000);
    wait_cycles(70);
    run_frame(32'h60880000, 32'h60880000, 32'hFFFC0000, 1'b1, 16'h1234);
    wait_cycles(70);

    run_frame(32'h5C2A0F0F, 32'h5C2A0F0F, 32'hFFFFFFFF, 1'b0, 16'h0000);
    wait_cycles(8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cycles(70);

    run_frame(32'h60880000, 32'h60880000, 32'hFFFC0000, 1'b1, 16'hFFFF);
    wait_cycles(70);
    run_frame(32'h5C2A0F0F, 32'h5C2A0F0F, 32'hFFFFFFFF, 1'b0, 16'h0000);
    wait_cycles(70);
    check("rd_data_held_after_write", rd_data, 16'hFFFF);

    @(negedge clk);
    tdata = 32'h5123ABCD;
    start = 1'b1;
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      e.e0 = c + 1 + 65 * k; e.out_bits = 32'h5123ABCD; e.oe_bits = 32'hFFFFFFFF;
      e.is_read = 1'b0; e.rd = 16'h0000;
      expq.push_back(e);
    end
    wait_cycles(140);
    start = 1'b0;
    wait_cycles(80);

    run_frame(32'h60880000, 32'h60880000, 32'hFFFC0000, 1'b1, 16'hA5A5);
    wait_cycles(40);
    #2 rst = 1'b0;
    #1 check("async_reset_outputs", {13'd0, mdc, mdio_out, mdio_oe, data_rdy, rd_data}, 32'd0);
    wait_cycles(3);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_after_reset", {30'd0, mdc, mdio_oe}, 32'd0);
    end
    wait_cycles(70);

    check("queue_drained", expq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
